// File: rtl/usart_rx_pkg.sv
// Shared types and decode helpers for the USART receive frame engine.
package usart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int DATA_W_LIMIT = 9;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  typedef struct packed {
    logic                    pe;
    logic                    fe;
    logic [DATA_W_LIMIT-1:0] data;
  } rx_entry_t;

  // A 9-bit code on an 8-bit build clamps to the widest supported length.
  function automatic logic [3:0] ucsz_to_len(input logic [2:0] ucsz, input int maxW);
    logic [3:0] len;
    case (ucsz)
      UCSZ_5:  len = 4'd5;
      UCSZ_6:  len = 4'd6;
      UCSZ_7:  len = 4'd7;
      UCSZ_8:  len = 4'd8;
      UCSZ_9:  len = 4'd9;
      default: len = 4'd8;
    endcase
    if (int'(len) > maxW) len = 4'(maxW);
    return len;
  endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// Synchronous receive FIFO; a pop frees a slot for a push in the same cycle.
module usart_rx_fifo
  import usart_rx_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             popOk, pushOk;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign popOk   = pop_i && !empty_o;
  assign pushOk  = push_i && (!full_o || popOk);
  assign level_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
      if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (pushOk && !flush_i) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/usart_rx_frame_engine.sv
// Oversampling USART receiver with internal frame FSM and receive FIFO.
// Optional multi-processor drop filter enabled by defining USART_RX_MPCM_EN.
module usart_rx_frame_engine
  import usart_rx_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_fosk,
  input  logic                          i_rst,
  input  logic                          i_rxd,
  input  logic                          i_rxclk,
  input  logic                          i_en,
  input  logic [2:0]                    i_ucsz,
  input  logic [1:0]                    i_upm,
  input  logic                          i_pop,
`ifdef USART_RX_MPCM_EN
  input  logic                          i_mpcm,
`endif
  output logic [DATA_W_MAX-1:0]         o_data,
  output logic                          o_fe,
  output logic                          o_pe,
  output logic                          o_dor,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy
);

  localparam int CNT_W  = $clog2(OVS);
  localparam int WORD_W = DATA_W_MAX + 2;
  localparam logic [CNT_W-1:0] TICK_DEC = CNT_W'(OVS/2 + 1);
  localparam logic [CNT_W-1:0] TICK_END = CNT_W'(OVS - 1);

  rx_state_e              state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [2:0]             samp_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bitIdx_q, bitIdx_d;
  logic [3:0]             len_q, len_d;
  logic                   parEn_q, parEn_d;
  logic                   parOdd_q, parOdd_d;
  logic [DATA_W_MAX-1:0]  data_q, data_d;
  logic                   pe_q, pe_d;
  logic                   dor_q, dor_d;

  logic [2:0]             sampNew;
  logic                   majBit;
  logic [CNT_W-1:0]       tickCur;
  logic                   isDec, isEnd;
  logic                   frameDone, frameFe;
  logic                   mpcmDrop, pushReq;
  logic                   fifoFull, fifoEmpty;
  rx_entry_t              pushEntry;
  logic [WORD_W-1:0]      pushWord, headWord;

  assign sampNew = {samp_q[1:0], sync2_q};
  assign majBit  = (sampNew[0] & sampNew[1]) | (sampNew[0] & sampNew[2]) | (sampNew[1] & sampNew[2]);
  assign tickCur = cnt_q + 1'b1;
  assign isDec   = (tickCur == TICK_DEC);
  assign isEnd   = (tickCur == TICK_END);

  // cnt_q holds the in-bit index of the latest tick; the falling-edge tick is index 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    len_d     = len_q;
    parEn_d   = parEn_q;
    parOdd_d  = parOdd_q;
    data_d    = data_q;
    pe_d      = pe_q;
    frameDone = 1'b0;
    frameFe   = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else if (i_rxclk) begin
      if (state_q != ST_IDLE) cnt_d = tickCur;
      case (state_q)
        ST_IDLE: begin
          if (samp_q[0] && !sync2_q) begin
            state_d  = ST_START;
            cnt_d    = '0;
            bitIdx_d = '0;
            len_d    = ucsz_to_len(i_ucsz, DATA_W_MAX);
            parEn_d  = (i_upm == UPM_EVEN) || (i_upm == UPM_ODD);
            parOdd_d = (i_upm == UPM_ODD);
            data_d   = '0;
            pe_d     = 1'b0;
          end
        end
        ST_START: begin
          if (isDec && majBit) state_d = ST_IDLE;
          else if (isEnd)      state_d = ST_DATA;
        end
        ST_DATA: begin
          if (isDec) data_d[bitIdx_q] = majBit;
          if (isEnd) begin
            if (bitIdx_q == len_q - 4'd1) state_d = parEn_q ? ST_PARITY : ST_STOP;
            else                          bitIdx_d = bitIdx_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (isDec) pe_d = majBit ^ (^data_q) ^ parOdd_q;
          if (isEnd) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (isDec) begin
            frameDone = 1'b1;
            frameFe   = ~majBit;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef USART_RX_MPCM_EN
  assign mpcmDrop = i_mpcm && (len_q == 4'd9) && !data_q[DATA_W_MAX-1];
`else
  assign mpcmDrop = 1'b0;
`endif

  assign pushReq = frameDone && !mpcmDrop;

  always_comb begin
    pushEntry                      = '0;
    pushEntry.pe                   = pe_q;
    pushEntry.fe                   = frameFe;
    pushEntry.data[DATA_W_MAX-1:0] = data_q;
  end

  assign pushWord = {pushEntry.pe, pushEntry.fe, pushEntry.data[DATA_W_MAX-1:0]};

  // Overrun only when the push really is refused, i.e. full with no pop alongside.
  always_comb begin
    dor_d = dor_q;
    if (!i_en)                                dor_d = 1'b0;
    else if (pushReq && fifoFull && !i_pop)   dor_d = 1'b1;
    else if (i_pop)                           dor_d = 1'b0;
  end

  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      samp_q   <= 3'b111;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      len_q    <= 4'd8;
      parEn_q  <= 1'b0;
      parOdd_q <= 1'b0;
      data_q   <= '0;
      pe_q     <= 1'b0;
      dor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= i_rxd;
      sync2_q  <= sync1_q;
      if (i_rxclk) samp_q <= sampNew;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      len_q    <= len_d;
      parEn_q  <= parEn_d;
      parOdd_q <= parOdd_d;
      data_q   <= data_d;
      pe_q     <= pe_d;
      dor_q    <= dor_d;
    end
  end

  usart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_fosk),
    .rst_i   (i_rst),
    .flush_i (!i_en),
    .push_i  (pushReq),
    .pop_i   (i_pop),
    .din_i   (pushWord),
    .dout_o  (headWord),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (o_level)
  );

  assign o_data  = headWord[DATA_W_MAX-1:0];
  assign o_fe    = headWord[DATA_W_MAX];
  assign o_pe    = headWord[DATA_W_MAX+1];
  assign o_valid = !fifoEmpty;
  assign o_dor   = dor_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usart_rx_frame_engine.sv
// Scoreboard bench for usart_rx_frame_engine; the MPCM scenario runs when USART_RX_MPCM_EN is defined.
module tb_usart_rx_frame_engine;

  localparam int DATA_W_MAX = 9;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int RXCLK_DIV  = 2;
  localparam int BIT_CYC    = OVS * RXCLK_DIV;
  localparam int WAIT_MAX   = 4 * BIT_CYC;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [8:0] data;
  } exp_t;

  logic                  i_fosk = 1'b0;
  logic                  i_rst, i_rxd, i_rxclk, i_en, i_pop;
  logic [2:0]            i_ucsz;
  logic [1:0]            i_upm;
`ifdef USART_RX_MPCM_EN
  logic                  i_mpcm;
`endif
  logic [DATA_W_MAX-1:0] o_data;
  logic                  o_fe, o_pe, o_dor, o_valid, o_busy;
  logic [LVL_W-1:0]      o_level;

  int   errors = 0;
  int   checks = 0;
  exp_t expQ[$];

  usart_rx_frame_engine #(
    .DATA_W_MAX (DATA_W_MAX),
    .OVS        (OVS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_fosk  (i_fosk),
    .i_rst   (i_rst),
    .i_rxd   (i_rxd),
    .i_rxclk (i_rxclk),
    .i_en    (i_en),
    .i_ucsz  (i_ucsz),
    .i_upm   (i_upm),
    .i_pop   (i_pop),
`ifdef USART_RX_MPCM_EN
    .i_mpcm  (i_mpcm),
`endif
    .o_data  (o_data),
    .o_fe    (o_fe),
    .o_pe    (o_pe),
    .o_dor   (o_dor),
    .o_valid (o_valid),
    .o_level (o_level),
    .o_busy  (o_busy)
  );

  // System clock; oversample tick is a one-cycle pulse every RXCLK_DIV cycles.
  always #5 i_fosk = ~i_fosk;

  initial begin
    int div;
    div = 0;
    i_rxclk = 1'b0;
    forever begin
      @(negedge i_fosk);
      div++;
      i_rxclk = ((div % RXCLK_DIV) == 0);
    end
  end

  // Expected parity error: the sent parity bit disagrees with the one a correct sender would use.
  function automatic logic expPe(input logic [8:0] d, input int nbits, input logic odd, input logic sentPar);
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < nbits; i++) ones = ones ^ d[i];
    return sentPar != (odd ? ~ones : ones);
  endfunction

  task automatic driveBit(input logic b);
    i_rxd = b;
    repeat (BIT_CYC) @(negedge i_fosk);
  endtask

  task automatic applyStimulus(input logic [8:0] d, input int nbits, input bit parEn,
                               input logic parBit, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < nbits; i++) driveBit(d[i]);
    if (parEn) driveBit(parBit);
    driveBit(stopBit);
  endtask

  task automatic popHead();
    @(negedge i_fosk);
    i_pop = 1'b1;
    @(negedge i_fosk);
    i_pop = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < WAIT_MAX; n++) begin
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_fosk);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_rxd = 1'b1; i_pop = 1'b0;
    i_ucsz = 3'b011; i_upm = 2'b00;
`ifdef USART_RX_MPCM_EN
    i_mpcm = 1'b0;
`endif
    repeat (4) @(negedge i_fosk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset valid: got %b want 0", o_valid); end
    checks++; if (o_level !== '0) begin errors++; $display("[TB] FAIL reset level: got %0d want 0", o_level); end
    checks++; if ({o_dor, o_busy} !== 2'b00) begin errors++; $display("[TB] FAIL reset dor/busy: got %b want 00", {o_dor, o_busy}); end
    checks++; if ({o_pe, o_fe, o_data} !== '0) begin errors++; $display("[TB] FAIL reset head: got %h want 0", {o_pe, o_fe, o_data}); end
    i_rst = 1'b0; i_en = 1'b1;
    repeat (2 * BIT_CYC) @(negedge i_fosk);
  endtask

  task automatic test_8n1();
    exp_t e;
    bit ok;
    i_ucsz = 3'b011; i_upm = 2'b00;
    expQ.push_back('{pe: 1'b0, fe: 1'b0, data: 9'h0A5});
    applyStimulus(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    waitValid(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL 8n1 valid: got %b want 1", o_valid); end
    e = expQ.pop_front();
    checks++; if (o_data !== e.data) begin errors++; $display("[TB] FAIL 8n1 data: got %h want %h", o_data, e.data); end
    checks++; if ({o_fe, o_pe} !== {e.fe, e.pe}) begin errors++; $display("[TB] FAIL 8n1 flags: got %b want %b", {o_fe, o_pe}, {e.fe, e.pe}); end
    popHead();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL 8n1 pop valid: got %b want 0", o_valid); end
    popHead();
    checks++; if (o_level !== '0) begin errors++; $display("[TB] FAIL empty pop level: got %0d want 0", o_level); end
  endtask

  task automatic test_parity9();
    exp_t e;
    i_ucsz = 3'b111; i_upm = 2'b10;
    expQ.push_back('{pe: expPe(9'h1FF, 9, 1'b0, 1'b1), fe: 1'b0, data: 9'h1FF});
    applyStimulus(9'h1FF, 9, 1'b1, 1'b1, 1'b1);
    expQ.push_back('{pe: expPe(9'h1FF, 9, 1'b0, 1'b0), fe: 1'b0, data: 9'h1FF});
    applyStimulus(9'h1FF, 9, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge i_fosk);
    checks++; if (o_level !== LVL_W'(2)) begin errors++; $display("[TB] FAIL parity level: got %0d want 2", o_level); end
    for (int k = 0; k < 2; k++) begin
      e = expQ.pop_front();
      checks++; if (o_data !== e.data) begin errors++; $display("[TB] FAIL parity data%0d: got %h want %h", k, o_data, e.data); end
      checks++; if (o_pe !== e.pe) begin errors++; $display("[TB] FAIL parity pe%0d: got %b want %b", k, o_pe, e.pe); end
      popHead();
    end
    i_ucsz = 3'b011; i_upm = 2'b00;
  endtask

  task automatic test_bad_stop();
    exp_t e;
    expQ.push_back('{pe: 1'b0, fe: 1'b1, data: 9'h03C});
    applyStimulus(9'h03C, 8, 1'b0, 1'b0, 1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    expQ.push_back('{pe: 1'b0, fe: 1'b0, data: 9'h055});
    applyStimulus(9'h055, 8, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge i_fosk);
    checks++; if (o_level !== LVL_W'(2)) begin errors++; $display("[TB] FAIL badstop level: got %0d want 2", o_level); end
    for (int k = 0; k < 2; k++) begin
      e = expQ.pop_front();
      checks++; if (o_data !== e.data) begin errors++; $display("[TB] FAIL badstop data%0d: got %h want %h", k, o_data, e.data); end
      checks++; if (o_fe !== e.fe) begin errors++; $display("[TB] FAIL badstop fe%0d: got %b want %b", k, o_fe, e.fe); end
      popHead();
    end
  endtask

  task automatic test_glitch();
    i_rxd = 1'b0;
    repeat (3 * RXCLK_DIV) @(negedge i_fosk);
    i_rxd = 1'b1;
    repeat (8) @(negedge i_fosk);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch start seen: got %b want 1", o_busy); end
    repeat (2 * BIT_CYC) @(negedge i_fosk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch busy: got %b want 0", o_busy); end
    checks++; if (o_level !== '0) begin errors++; $display("[TB] FAIL glitch level: got %0d want 0", o_level); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int v = 1; v <= 5; v++) begin
      if (v <= FIFO_DEPTH) expQ.push_back('{pe: 1'b0, fe: 1'b0, data: 9'(v)});
      applyStimulus(9'(v), 8, 1'b0, 1'b0, 1'b1);
    end
    repeat (4) @(negedge i_fosk);
    checks++; if (o_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("[TB] FAIL b2b level: got %0d want %0d", o_level, FIFO_DEPTH); end
    checks++; if (o_dor !== 1'b1) begin errors++; $display("[TB] FAIL b2b dor set: got %b want 1", o_dor); end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      e = expQ.pop_front();
      checks++; if (o_data !== e.data) begin errors++; $display("[TB] FAIL b2b data%0d: got %h want %h", k, o_data, e.data); end
      popHead();
      if (k == 0) begin
        checks++; if (o_dor !== 1'b0) begin errors++; $display("[TB] FAIL b2b dor clear: got %b want 0", o_dor); end
      end
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b drained: got %b want 0", o_valid); end
  endtask

  task automatic test_enable_drop();
    applyStimulus(9'h033, 8, 1'b0, 1'b0, 1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    checks++; if ({o_busy, o_level} !== {1'b1, LVL_W'(1)}) begin errors++; $display("[TB] FAIL en pre busy/level: got %b/%0d want 1/1", o_busy, o_level); end
    i_en = 1'b0;
    @(negedge i_fosk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL en busy: got %b want 0", o_busy); end
    checks++; if (o_level !== '0) begin errors++; $display("[TB] FAIL en level: got %0d want 0", o_level); end
    i_rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge i_fosk);
    i_en = 1'b1;
    repeat (BIT_CYC) @(negedge i_fosk);
  endtask

  task automatic test_reset_midframe();
    driveBit(1'b0);
    driveBit(1'b1);
    i_rst = 1'b1;
    @(negedge i_fosk);
    checks++; if ({o_busy, o_valid} !== 2'b00) begin errors++; $display("[TB] FAIL midreset busy/valid: got %b want 00", {o_busy, o_valid}); end
    i_rst = 1'b0;
    i_rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge i_fosk);
  endtask

`ifdef USART_RX_MPCM_EN
  task automatic test_mpcm();
    exp_t e;
    i_mpcm = 1'b1; i_ucsz = 3'b111; i_upm = 2'b00;
    applyStimulus(9'h012, 9, 1'b0, 1'b0, 1'b1);
    expQ.push_back('{pe: 1'b0, fe: 1'b0, data: 9'h1AB});
    applyStimulus(9'h1AB, 9, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge i_fosk);
    checks++; if (o_level !== LVL_W'(1)) begin errors++; $display("[TB] FAIL mpcm level: got %0d want 1", o_level); end
    e = expQ.pop_front();
    checks++; if (o_data !== e.data) begin errors++; $display("[TB] FAIL mpcm data: got %h want %h", o_data, e.data); end
    checks++; if (o_dor !== 1'b0) begin errors++; $display("[TB] FAIL mpcm dor: got %b want 0", o_dor); end
    popHead();
    i_mpcm = 1'b0; i_ucsz = 3'b011;
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity9();
    test_bad_stop();
    test_glitch();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
`ifdef USART_RX_MPCM_EN
    test_mpcm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
